// File: rtl/aes_pkg.sv
// Shared definitions for the AES job scheduler.
// Holds the scheduler FSM state encoding and the default block and timeout
// sizes. It also provides a width helper that never returns zero, so that
// single-entry configurations still get 1-bit index registers.
package aes_pkg;

  localparam int AES_BLOCK_BYTES    = 16;
  localparam int AES_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   req_i       - request vector, one bit per requester
//   advance_i   - grant accepted this cycle; the pointer moves past the winner
//   grant_o     - one-hot winner (all zero when no request is present)
//   idx_o       - binary index of the winner
//   valid_o     - at least one request is present
// The search starts at ptr_q, which always names the requester after the
// last one granted. After reset that is requester 0.
module aes_rr_arbiter import aes_pkg::*; #(
  parameter int NREQ = 2,
  parameter int IDW  = idx_width(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            valid_o
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;
  logic           found;

  // Walk the requesters in rotated order (ptr, ptr+1, ... modulo NREQ) and
  // keep the first one that is requesting.
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      cand = sum[IDW-1:0];
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
  end

  assign valid_o = found;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_grant
      assign grant_o[gi] = found && (idx_o == IDW'(gi));
    end
  endgenerate

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (idx_o == IDW'(NREQ-1)) ? '0 : idx_o + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one byte-serial AES encrypt unit between NREQ requesters.
// A job moves through five phases:
//   1. IDLE picks a requester round-robin.
//   2. FILL collects BLOCK_BYTES plaintext bytes from that requester.
//   3. LAUNCH streams the buffered block into the engine back-to-back.
//   4. WAIT waits for the engine to start answering, with a timeout.
//   5. DRAIN forwards the ciphertext bytes combinationally.
// Ports:
//   clk, reset               - clock and asynchronous active-high reset
//   req_valid/req_data       - per-requester byte lanes (lane i = bits 8i+7:8i)
//   req_ready                - byte from the owning requester accepted
//   eu_valid_input/eu_data_in   - byte stream into the encrypt unit
//   eu_valid_output/eu_data_out - byte stream from the encrypt unit
//   rsp_valid/rsp_data/rsp_id/rsp_last - ciphertext to the owner, no backpressure
//   busy                     - a job is in progress
//   error                    - one-cycle pulse when a job is aborted
module aes_job_scheduler import aes_pkg::*; #(
  parameter  int NREQ           = 2,
  parameter  int BLOCK_BYTES    = AES_BLOCK_BYTES,
  parameter  int TIMEOUT_CYCLES = AES_TIMEOUT_CYCLES,
  localparam int IDW            = idx_width(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              eu_valid_input,
  output logic [7:0]        eu_data_in,
  input  logic              eu_valid_output,
  input  logic [7:0]        eu_data_out,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_last,
  output logic              busy,
  output logic              error
);

  localparam int CW = idx_width(BLOCK_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(BLOCK_BYTES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] owner_q, owner_d;
  logic            error_q, error_d;
  logic [7:0]      buf_q [BLOCK_BYTES];

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_idx;
  logic            arb_valid;
  logic            arb_advance;
  logic            fill_accept;
  logic            cnt_last;
  logic            eng_window;
  logic [7:0]      lane_data;

  aes_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_valid),
    .advance_i (arb_advance),
    .grant_o   (arb_grant),
    .idx_o     (arb_idx),
    .valid_o   (arb_valid)
  );

  assign cnt_last    = (cnt_q == CNT_LAST);
  assign fill_accept = |(req_valid & req_ready);
  assign lane_data   = req_data[{id_q, 3'b000} +: 8];
  // Engine output is only meaningful once the block has been launched.
  assign eng_window  = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

  // Plaintext buffer: one write port (FILL) and one read port (LAUNCH).
  // The buffer has no reset; stale contents are always overwritten before
  // they are launched.
  always_ff @(posedge clk) begin
    if (fill_accept) begin
      buf_q[cnt_q] <= lane_data;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      id_q    <= '0;
      owner_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      id_q    <= id_d;
      owner_q <= owner_d;
      error_q <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    id_d        = id_q;
    owner_d     = owner_q;
    error_d     = 1'b0;
    arb_advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        timer_d = '0;
        if (arb_valid) begin
          arb_advance = 1'b1;
          id_d        = arb_idx;
          owner_d     = arb_grant;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        if (fill_accept) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = ST_LAUNCH;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_LAUNCH: begin
        if (cnt_last) begin
          cnt_d   = '0;
          timer_d = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT: begin
        // The first engine byte is forwarded in this same cycle as byte 0.
        if (eu_valid_output) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = ST_DRAIN;
          end
        end else if (timer_q >= TIMER_LAST) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (eu_valid_output) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          // The engine stopped early, so the response is incomplete.
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    req_ready      = (state_q == ST_FILL) ? owner_q : '0;
    eu_valid_input = (state_q == ST_LAUNCH);
    eu_data_in     = (state_q == ST_LAUNCH) ? buf_q[cnt_q] : 8'h00;
    rsp_valid      = eng_window && eu_valid_output;
    rsp_data       = rsp_valid ? eu_data_out : 8'h00;
    rsp_last       = rsp_valid && cnt_last;
    rsp_id         = id_q;
    busy           = (state_q != ST_IDLE);
    error          = error_q;
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
module tb_aes_job_scheduler;

  localparam int NREQ = 2;
  localparam int BB   = 16;
  localparam int TMO  = 64;
  localparam int LAT  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        eu_valid_input;
  logic [7:0]  eu_data_in;
  logic        eng_vo;
  logic        spur_vo;
  logic [7:0]  eng_do;
  logic        eu_valid_output;
  logic [7:0]  eu_data_out;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [0:0]  rsp_id;
  logic        rsp_last;
  logic        busy;
  logic        error;

  assign eu_valid_output = eng_vo | spur_vo;
  assign eu_data_out     = eng_do;

  always #5 clk = ~clk;

  aes_job_scheduler #(
    .NREQ           (NREQ),
    .BLOCK_BYTES    (BB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .eu_valid_input  (eu_valid_input),
    .eu_data_in      (eu_data_in),
    .eu_valid_output (eu_valid_output),
    .eu_data_out     (eu_data_out),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_id          (rsp_id),
    .rsp_last        (rsp_last),
    .busy            (busy),
    .error           (error)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       id;
    logic       last;
  } exp_t;

  exp_t        exp_q [$];
  logic [7:0]  rq0 [$];
  logic [7:0]  rq1 [$];
  logic [127:0] fips_pt = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] fips_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rsp_seen = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int run = 0;
  int last_run = 0;
  int last_launch_cyc = 0;
  int eng_mode = 0;   // 0 normal, 1 silent, 2 stops after 10 bytes
  logic stall = 1'b0;
  logic phase = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("check %s ok: %0h", nm, act);
    end
  endtask

  // Queue a plaintext block on a lane and push the expected ciphertext.
  // For the FIPS-197 vector the engine model returns the real ciphertext;
  // for any other block it returns byte ^ (0x5A + index).
  task automatic load(input int lane, input logic [127:0] pt, input int nexp);
    logic [7:0] b;
    exp_t e;
    for (int i = 0; i < BB; i++) begin
      b = pt[127-8*i -: 8];
      if (lane == 0) rq0.push_back(b);
      else rq1.push_back(b);
    end
    for (int i = 0; i < nexp; i++) begin
      b = pt[127-8*i -: 8];
      e.d    = (pt == fips_pt) ? fips_ct[127-8*i -: 8] : (b ^ (8'h5A + 8'(i)));
      e.id   = (lane != 0);
      e.last = (i == BB - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || busy || rq0.size() > 0 || rq1.size() > 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_completes"}, 32'(k < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Requester driver: present the head byte on each lane; a byte shown while
  // req_ready is high is taken at the next rising edge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      phase = ~phase;
      if (rq0.size() > 0 && (!stall || phase)) begin
        req_valid[0]   = 1'b1;
        req_data[7:0]  = rq0[0];
        if (req_ready[0]) void'(rq0.pop_front());
      end else begin
        req_valid[0] = 1'b0;
      end
      if (rq1.size() > 0 && (!stall || phase)) begin
        req_valid[1]   = 1'b1;
        req_data[15:8] = rq1[0];
        if (req_ready[1]) void'(rq1.pop_front());
      end else begin
        req_valid[1] = 1'b0;
      end
    end
  end

  // Encrypt unit model: collect a block, wait LAT cycles, stream the answer.
  initial begin
    int n;
    int nout;
    logic [7:0] blk [BB];
    logic [7:0] ob  [BB];
    logic [127:0] pt;
    eng_vo = 1'b0;
    eng_do = 8'h00;
    forever begin
      n = 0;
      while (n < BB) begin
        @(negedge clk);
        if (reset) n = 0;
        else if (eu_valid_input) begin
          blk[n] = eu_data_in;
          n++;
        end
      end
      for (int i = 0; i < BB; i++) pt[127-8*i -: 8] = blk[i];
      for (int i = 0; i < BB; i++)
        ob[i] = (pt == fips_pt) ? fips_ct[127-8*i -: 8] : (blk[i] ^ (8'h5A + 8'(i)));
      nout = (eng_mode == 1) ? 0 : (eng_mode == 2) ? 10 : BB;
      repeat (LAT) @(posedge clk);
      for (int i = 0; i < nout; i++) begin
        @(posedge clk);
        #1;
        eng_vo = 1'b1;
        eng_do = ob[i];
      end
      @(posedge clk);
      #1;
      eng_vo = 1'b0;
      eng_do = 8'h00;
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rsp_unexpected: got data %0h id %0d last %0d, expected no response",
                   rsp_data, rsp_id, rsp_last);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.d));
          chk("rsp_id",   32'(rsp_id),   32'(e.id));
          chk("rsp_last", 32'(rsp_last), 32'(e.last));
        end
      end
      if (error) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (eu_valid_input) begin
        run++;
        last_launch_cyc = cyc;
      end else if (run > 0) begin
        last_run = run;
        run = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int err0;
    int seen0;
    int k;
    reset   = 1'b1;
    spur_vo = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_eu_valid_input", 32'(eu_valid_input), 32'd0);
    chk("reset_eu_data_in", 32'(eu_data_in), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_last", 32'(rsp_last), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    reset = 1'b0;

    // Single FIPS-197 job from requester 0
    err0 = err_cnt;
    load(0, fips_pt, 16);
    wait_done("single", 500);
    chk("single_launch_len", 32'(last_run), 32'd16);
    chk("single_no_error", 32'(err_cnt), 32'(err0));

    // Stalled fill
    stall = 1'b1;
    load(0, fips_pt, 16);
    wait_done("stall", 800);
    chk("stall_launch_len", 32'(last_run), 32'd16);
    stall = 1'b0;

    // Contention from reset: grants 0,1,0,1
    reset = 1'b1;
    @(negedge clk);
    err0 = err_cnt;
    load(0, 128'h101112131415161718191a1b1c1d1e1f, 16);
    load(1, 128'h808182838485868788898a8b8c8d8e8f, 16);
    load(0, 128'h303132333435363738393a3b3c3d3e3f, 16);
    load(1, 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, 16);
    @(negedge clk);
    reset = 1'b0;
    wait_done("contention", 2000);
    chk("contention_no_error", 32'(err_cnt), 32'(err0));

    // Timeout: engine never answers
    eng_mode = 1;
    err0 = err_cnt;
    load(0, 128'h0102030405060708090a0b0c0d0e0f10, 0);
    k = 0;
    while (err_cnt == err0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_error_seen", 32'(err_cnt != err0), 32'd1);
    chk("timeout_delay", 32'(err_cyc - last_launch_cyc), 32'(TMO + 1));
    chk("timeout_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    chk("timeout_error_pulse", 32'(error), 32'd0);
    eng_mode = 0;
    load(1, 128'hdeadbeef0123456789abcdef55aa33cc, 16);
    wait_done("after_timeout", 500);
    chk("timeout_error_count", 32'(err_cnt), 32'(err0 + 1));

    // Engine stops after 10 bytes
    eng_mode = 2;
    err0  = err_cnt;
    seen0 = rsp_seen;
    load(0, 128'h00000000ffffffff12345678a5a5a5a5, 10);
    wait_done("short", 500);
    chk("short_rsp_count", 32'(rsp_seen - seen0), 32'd10);
    chk("short_error_count", 32'(err_cnt), 32'(err0 + 1));
    eng_mode = 0;

    // Engine output while idle must be ignored
    seen0 = rsp_seen;
    @(posedge clk);
    #1 spur_vo = 1'b1;
    repeat (3) @(posedge clk);
    #1 spur_vo = 1'b0;
    repeat (2) @(negedge clk);
    chk("spurious_ignored", 32'(rsp_seen - seen0), 32'd0);
    chk("spurious_busy", 32'(busy), 32'd0);

    // Reset in LAUNCH byte 5
    load(0, 128'h11223344556677889900aabbccddeeff, 0);
    k = 0;
    while (k < 6 && cyc < 100000) begin
      @(negedge clk);
      if (eu_valid_input) k++;
    end
    chk("launch_reached", 32'(k), 32'd6);
    reset = 1'b1;
    #1;
    chk("rst_launch_eu_valid_input", 32'(eu_valid_input), 32'd0);
    chk("rst_launch_eu_data_in", 32'(eu_data_in), 32'd0);
    chk("rst_launch_busy", 32'(busy), 32'd0);
    chk("rst_launch_req_ready", 32'(req_ready), 32'd0);
    chk("rst_launch_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_launch_error", 32'(error), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    err0  = err_cnt;
    seen0 = rsp_seen;
    repeat (100) @(negedge clk);
    chk("rst_launch_no_rsp", 32'(rsp_seen - seen0), 32'd0);
    chk("rst_launch_no_error", 32'(err_cnt), 32'(err0));
    chk("rst_launch_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_job_scheduler.md
AES_JOB_SCHEDULER -- requirements
Module: aes_job_scheduler

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing one byte-serial AES encrypt unit.
REQ-002 Parameter BLOCK_BYTES, default 16: bytes per AES block.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: maximum WAIT-state cycles before abort.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  NREQ  requester i presents a plaintext byte.
REQ-007 req_data  in  NREQ*8  byte lane i = req_data[8i+7:8i].
REQ-008 req_ready  out  NREQ  byte from requester i accepted this cycle when req_valid[i] & req_ready[i].
REQ-009 eu_valid_input  out  1  drives encrypt unit valid_input.
REQ-010 eu_data_in  out  8  drives encrypt unit data_in.
REQ-011 eu_valid_output  in  1  from encrypt unit valid_output.
REQ-012 eu_data_out  in  8  from encrypt unit data_out.
REQ-013 rsp_valid  out  1  ciphertext byte valid (no backpressure).
REQ-014 rsp_data  out  8  ciphertext byte.
REQ-015 rsp_id  out  clog2(NREQ)  owner of current job.
REQ-016 rsp_last  out  1  marks byte BLOCK_BYTES-1 of a response.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 error  out  1  one-cycle pulse on job abort.

Function
REQ-019 FSM states SHALL be IDLE, FILL, LAUNCH, WAIT, DRAIN.
REQ-020 IDLE: with any req_valid set, grant the round-robin winner (search from the requester after the last granted one; requester 0 first after reset), latch its id, go to FILL; req_ready all zero in IDLE.
REQ-021 FILL: req_ready high only for the granted id; each accepted byte written to buffer[cnt], cnt incremented; gaps in req_valid stall without loss; after byte BLOCK_BYTES-1 go to LAUNCH.
REQ-022 LAUNCH: eu_valid_input high for exactly BLOCK_BYTES consecutive cycles, eu_data_in = buffer[cnt] with cnt from 0; then WAIT.
REQ-023 WAIT: timer counts cycles; eu_valid_output high goes to DRAIN and that cycle's byte is forwarded as DRAIN byte 0; timer reaching TIMEOUT_CYCLES pulses error and returns to IDLE.
REQ-024 DRAIN: rsp_valid = eu_valid_output, rsp_data = eu_data_out combinationally, rsp_id = latched id; rsp_last on byte BLOCK_BYTES-1, then IDLE.
REQ-025 eu_valid_output dropping before BLOCK_BYTES bytes SHALL pulse error, suppress rsp_last, return to IDLE.
REQ-026 eu_valid_output asserted outside WAIT/DRAIN SHALL be ignored (no rsp_valid).
REQ-027 Round-robin pointer updates only on grant; a requester holding req_valid is granted within NREQ jobs.
REQ-028 Requests arriving in FILL..DRAIN wait; one job in flight at a time.
REQ-029 Minimum job latency, first accepted byte to rsp_last: BLOCK_BYTES fill + BLOCK_BYTES launch + engine latency + BLOCK_BYTES drain cycles.
REQ-030 cnt width clog2(BLOCK_BYTES), wraps to 0 on each state exit; timer saturates, never wraps.

Reset
REQ-031 On reset: state IDLE, cnt 0, timer 0, rr pointer to requester 0, latched id 0; outputs req_ready 0, eu_valid_input 0, eu_data_in 0, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_last 0, busy 0, error 0.
REQ-032 Reset mid-job SHALL discard the partial job with no rsp_valid or error after release; buffer contents need not be cleared.

Structure
REQ-033 State enum, BLOCK_BYTES and TIMEOUT_CYCLES defaults SHALL live in shared package aes_pkg.
REQ-034 Round-robin arbitration SHALL be sub-module aes_rr_arbiter (req vector, advance strobe -> one-hot grant, index).
REQ-035 Buffer is a BLOCK_BYTES x 8 register array, one write and one read port.

Verification
REQ-036 Single job: requester 0 sends 00112233445566778899aabbccddeeff, key memory 000102..0f -> rsp bytes 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id 0, rsp_last on byte 15.
REQ-037 Contention: both req_valid held from reset -> grants 0,1,0,1; each response carries the correct rsp_id.
REQ-038 Stalled fill: req_valid toggled every other cycle -> eu_valid_input still exactly 16 contiguous cycles, same ciphertext as REQ-036.
REQ-039 Timeout: engine model never asserts eu_valid_output -> error pulse TIMEOUT_CYCLES cycles after WAIT entry, busy falls, next job served.
REQ-040 Short output: eu_valid_output drops after 10 bytes -> 10 rsp_valid, no rsp_last, one error pulse.
REQ-041 Reset asserted in LAUNCH byte 5 -> all outputs 0 immediately, no response after release.
